inst_fetch_unit: RTL and testbench
==================================

// Module: inst_fetch_unit
// PURPOSE
//  Fetch stage feeding the KLP32 decode/execute datapath. Keeps a fetch PC and issues
//  word requests to an instruction-memory bus (req/gnt/rvalid, variable latency, in-order).
//  Buffers returned words with their PC in a small FIFO. Presents them downstream with a
//  valid/ready handshake. Branch/jump redirects flush the FIFO, and stale in-flight responses are drained.
// PARAMETERS
//  RESET_PC    32'h0000_0000  first fetch address after reset; bits [1:0] must be 0
//  FIFO_DEPTH  2              instruction buffer entries (>=2); also caps in-flight requests
// PORTS
//  clk             in   1   clock, all state on rising edge
//  reset           in   1   asynchronous, active-low reset
//  redirect_valid  in   1   branch/jump taken this cycle; flush and refetch
//  redirect_pc     in   32  redirect target; bits [1:0] ignored (forced 0)
//  imem_req        out  1   request valid to instruction memory
//  imem_addr       out  32  word-aligned request address
//  imem_gnt        in   1   request accepted this cycle (req & gnt = handshake)
//  imem_rvalid     in   1   response word valid, one per granted request, in order
//  imem_rdata      in   32  response instruction word
//  inst_valid      out  1   FIFO head valid
//  inst_ready      in   1   consumer accepts head this cycle
//  inst            out  32  head instruction word
//  inst_pc         out  32  PC of head instruction
//  inst_pc_inc     out  32  inst_pc + 4 (wraps mod 2^32)
// BEHAVIOUR
//  Reset (reset=0, async):
//   - fetch_pc=RESET_PC, FIFO empty, outstanding=0, state=FETCH.
//   - imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst/inst_pc=0, inst_pc_inc=4.
//   - Memory must be reset with the same signal; no pre-reset response may arrive after release.
//  Counters and credit:
//   - outstanding = granted minus responded (0..FIFO_DEPTH).
//   - pop = inst_valid & inst_ready.
//   - Issue credit: outstanding + occupancy - pop < FIFO_DEPTH (imem_req may depend combinationally on inst_ready).
//   - Credit guarantees the FIFO never overflows.
//  States:
//   - FETCH: imem_req=credit, imem_addr=fetch_pc. On req&gnt: fetch_pc+=4 (wraps 32'hFFFF_FFFC->0) and outstanding+1.
//   - A pending req with no gnt holds imem_addr stable until granted. It is not withdrawn, even on redirect.
//   - DRAIN: entered on redirect while outstanding>0, or while a req is pending ungranted (that req still
//     completes). New requests are blocked and every rvalid is discarded.
//   - DRAIN exits to FETCH in the cycle after outstanding reaches 0, with fetch_pc=latched target.
//  Redirect:
//   - At the edge: FIFO cleared and target latched (low bits zeroed).
//   - If nothing is in flight, fetch_pc=target and stay in FETCH; the next cycle requests the target.
//   - A redirect during DRAIN overwrites the latched target.
//   - A pop in the redirect cycle completes normally. The consumer squashes it.
//   - rvalid in the redirect cycle is discarded, and it counts against outstanding.
//  Response path:
//   - In FETCH, rvalid pushes {rdata, pc-of-request} at the edge.
//   - The PC comes from an internal in-flight PC queue, in order.
//   - Push and pop may occur in the same cycle; occupancy is then unchanged.
//  Latency:
//   - The word is visible (inst_valid=1) the cycle after rvalid.
//   - With gnt same-cycle and rvalid next-cycle memory, this gives 1 instruction/cycle sustained for FIFO_DEPTH>=2.
//  Outputs: inst_valid/inst/inst_pc are registered FIFO head only, with no combinational path from redirect_valid.
//  Errors: rvalid with outstanding==0 is illegal. Flag with a simulation assertion; no state change.
// TESTING
//  - Reset release, 1-cycle memory, ready=1:
//     - req at 0x0 in the first cycle after release.
//     - inst_valid with pc 0x0,0x4,0x8 on consecutive cycles and no bubbles.
//     - inst_pc_inc 0x4,0x8,0xC.
//  - inst_ready=0 for 10 cycles:
//     - FIFO fills to FIFO_DEPTH, then imem_req=0.
//     - On ready=1, PCs resume in order with none lost or duplicated.
//  - Redirect to 0x100 with 2 requests outstanding and 3-cycle rvalid:
//     - Both stale words are dropped, and DRAIN lasts until outstanding=0.
//     - Next request is to 0x100; next inst_pc=0x100.
//  - Redirect to 0x203 while req 0x10 is pending ungranted (gnt low 4 cycles):
//     - imem_addr holds 0x10 until gnt, and that response is discarded.
//     - Then fetch 0x200.
//  - Async reset asserted mid-DRAIN with FIFO non-empty:
//     - Outputs go immediately to reset values.
//     - After release, fetch restarts at RESET_PC.
//  - fetch_pc=0xFFFF_FFFC, one fetch:
//     - inst_pc_inc=0x0, and the next imem_addr=0x0.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// KLP32 fetch stage: issues word requests to instruction memory, buffers returned words with
// their PC, and drains stale responses after a branch/jump redirect.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc_inc
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic {FETCH, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   target_q, target_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] count_q, count_d;
  logic          pend_q, pend_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [PW-1:0] pcq_rd_q, pcq_rd_d, pcq_wr_q, pcq_wr_d;
  logic [31:0]   data_q [FIFO_DEPTH];
  logic [31:0]   data_d [FIFO_DEPTH];
  logic [31:0]   fpc_q  [FIFO_DEPTH];
  logic [31:0]   fpc_d  [FIFO_DEPTH];
  logic [31:0]   pcq_q  [FIFO_DEPTH];
  logic [31:0]   pcq_d  [FIFO_DEPTH];

  logic          rsp, pop, push, grant, credit;
  logic [CW:0]   committed;
  logic [31:0]   tgt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A response with nothing outstanding is ignored rather than corrupting the counters.
  assign rsp       = imem_rvalid && (outstanding_q != '0);
  assign inst_valid = (count_q != '0);
  assign pop       = inst_valid && inst_ready;
  assign committed = {1'b0, outstanding_q} + {1'b0, count_q} - {{CW{1'b0}}, pop};
  assign credit    = (committed < DEPTH_W);
  // A request left ungranted stays up even through a redirect or drain.
  assign imem_req  = reset && (pend_q || ((state_q == FETCH) && credit));
  assign imem_addr = fetch_pc_q;
  assign grant     = imem_req && imem_gnt;
  assign push      = (state_q == FETCH) && rsp && !redirect_valid;

  assign inst        = inst_valid ? data_q[rd_q] : '0;
  assign inst_pc     = inst_valid ? fpc_q[rd_q] : '0;
  assign inst_pc_inc = inst_pc + 32'd4;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    target_d      = target_q;
    rd_d          = rd_q;
    wr_d          = wr_q;
    pcq_rd_d      = pcq_rd_q;
    pcq_wr_d      = pcq_wr_q;
    data_d        = data_q;
    fpc_d         = fpc_q;
    pcq_d         = pcq_q;
    tgt           = target_q;
    outstanding_d = outstanding_q + CW'(grant) - CW'(rsp);
    count_d       = count_q + CW'(push) - CW'(pop);
    pend_d        = imem_req && !imem_gnt;

    if (grant) begin
      pcq_d[pcq_wr_q] = fetch_pc_q;
      pcq_wr_d        = ptr_inc(pcq_wr_q);
    end
    if (rsp) pcq_rd_d = ptr_inc(pcq_rd_q);
    if ((state_q == FETCH) && grant) fetch_pc_d = fetch_pc_q + 32'd4;

    if (push) begin
      data_d[wr_q] = imem_rdata;
      fpc_d[wr_q]  = pcq_q[pcq_rd_q];
      wr_d         = ptr_inc(wr_q);
    end
    if (pop) rd_d = ptr_inc(rd_q);

    if (redirect_valid) begin
      count_d = '0;
      rd_d    = '0;
      wr_d    = '0;
      tgt     = redirect_pc & 32'hFFFF_FFFC;
    end

    // Refetch from the target only once every older request has been answered.
    if (redirect_valid || (state_q == DRAIN)) begin
      target_d = tgt;
      if ((outstanding_d == '0) && !pend_d) begin
        state_d    = FETCH;
        fetch_pc_d = tgt;
      end else begin
        state_d = DRAIN;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= FETCH;
      fetch_pc_q    <= RESET_PC;
      target_q      <= RESET_PC;
      outstanding_q <= '0;
      count_q       <= '0;
      pend_q        <= 1'b0;
      rd_q          <= '0;
      wr_q          <= '0;
      pcq_rd_q      <= '0;
      pcq_wr_q      <= '0;
      data_q        <= '{default: '0};
      fpc_q         <= '{default: '0};
      pcq_q         <= '{default: '0};
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      target_q      <= target_d;
      outstanding_q <= outstanding_d;
      count_q       <= count_d;
      pend_q        <= pend_d;
      rd_q          <= rd_d;
      wr_q          <= wr_d;
      pcq_rd_q      <= pcq_rd_d;
      pcq_wr_q      <= pcq_wr_d;
      data_q        <= data_d;
      fpc_q         <= fpc_d;
      pcq_q         <= pcq_d;
    end
  end

  // Memory must never answer more requests than it has granted.
  assert property (@(posedge clk) disable iff (!reset) imem_rvalid |-> (outstanding_q != '0));

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomized bench for inst_fetch_unit: an in-order variable-latency memory model and a
// transaction-level model of the expected instruction stream and request behaviour.
module tb_inst_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          FIFO_DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_inc;

  always #5 clk = ~clk;

  inst_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_pc_inc    (inst_pc_inc)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } mem_txn_t;

  mem_txn_t    mem_q[$];
  int          num_checks = 0;
  int          num_errors = 0;
  int          cyc = 0;
  int          cur_epoch = 0;
  int          occ = 0;
  int          popped = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] exp_fetch = RESET_PC;
  logic [31:0] held_addr = '0;
  bit          old_pending = 1'b0;
  bit          pend_hold = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_F00D;
  endfunction

  function automatic bit any_stale();
    foreach (mem_q[i]) if (mem_q[i].epoch != cur_epoch) return 1'b1;
    return 1'b0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // Asynchronous reset of DUT and memory, asserted away from the clock edge.
  task automatic doReset();
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    redirect_valid = 1'b0;
    inst_ready     = 1'b1;
    #2 reset = 1'b0;
    #1;
    checkOutput("rst_imem_req", 32'(imem_req), 32'd0);
    checkOutput("rst_imem_addr", imem_addr, RESET_PC);
    checkOutput("rst_inst_valid", 32'(inst_valid), 32'd0);
    checkOutput("rst_inst", inst, 32'd0);
    checkOutput("rst_inst_pc", inst_pc, 32'd0);
    checkOutput("rst_inst_pc_inc", inst_pc_inc, 32'd4);
    mem_q.delete();
    occ         = 0;
    exp_pc      = RESET_PC;
    exp_fetch   = RESET_PC;
    old_pending = 1'b0;
    pend_hold   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // One clock cycle: drive inputs at the falling edge, check, then advance the model.
  task automatic applyStimulus(input bit gnt, input bit rdy, input bit redir, input logic [31:0] tgt);
    bit       exp_valid, pop, draining, credit, exp_req, rsp;
    mem_txn_t txn;
    imem_gnt       = gnt;
    inst_ready     = rdy;
    redirect_valid = redir;
    redirect_pc    = tgt;
    rsp            = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imem_rvalid    = rsp;
    imem_rdata     = rsp ? mem_word(mem_q[0].addr) : $urandom;
    #1;
    exp_valid = (occ > 0);
    checkOutput("inst_valid", 32'(inst_valid), 32'(exp_valid));
    if (exp_valid) begin
      checkOutput("inst_pc", inst_pc, exp_pc);
      checkOutput("inst", inst, mem_word(exp_pc));
      checkOutput("inst_pc_inc", inst_pc_inc, exp_pc + 32'd4);
    end
    pop      = exp_valid && rdy;
    draining = old_pending || any_stale();
    credit   = (mem_q.size() + occ - int'(pop)) < FIFO_DEPTH;
    exp_req  = pend_hold || (!draining && credit);
    checkOutput("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) checkOutput("imem_addr", imem_addr, pend_hold ? held_addr : exp_fetch);

    if (imem_req && gnt) begin
      txn.addr = imem_addr;
      txn.due  = cyc + $urandom_range(lat_max, lat_min);
      if (old_pending) begin
        txn.epoch   = -1;
        old_pending = 1'b0;
      end else begin
        txn.epoch = cur_epoch;
        exp_fetch = exp_fetch + 32'd4;
      end
      mem_q.push_back(txn);
    end
    if (rsp) begin
      txn = mem_q.pop_front();
      if ((txn.epoch == cur_epoch) && !redir) occ++;
    end
    if (pop) begin
      occ--;
      exp_pc = exp_pc + 32'd4;
      popped++;
    end
    if (redir) begin
      occ       = 0;
      exp_pc    = tgt & 32'hFFFF_FFFC;
      exp_fetch = tgt & 32'hFFFF_FFFC;
      cur_epoch++;
      if (imem_req && !gnt) old_pending = 1'b1;
    end
    pend_hold = imem_req && !gnt;
    held_addr = imem_addr;
    cyc++;
    @(negedge clk);
  endtask

  task automatic runRandom(input int n, input int gnt_pct, input int rdy_pct, input int redir_pct);
    logic [31:0] tgt;
    for (int i = 0; i < n; i++) begin
      tgt = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF4 + ($urandom & 32'h7)) : $urandom;
      applyStimulus($urandom_range(99, 0) < gnt_pct, $urandom_range(99, 0) < rdy_pct,
                    $urandom_range(99, 0) < redir_pct, tgt);
    end
  endtask

  initial begin
    doReset();

    $display("[TB] streaming from single-cycle memory");
    lat_min = 1; lat_max = 1;
    repeat (12) applyStimulus(1'b1, 1'b1, 1'b0, '0);

    $display("[TB] consumer stalled for 10 cycles");
    repeat (10) applyStimulus(1'b1, 1'b0, 1'b0, '0);
    repeat (10) applyStimulus(1'b1, 1'b1, 1'b0, '0);

    $display("[TB] redirect to 0x100 with 3-cycle memory");
    lat_min = 3; lat_max = 3;
    repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0100);
    repeat (12) applyStimulus(1'b1, 1'b1, 1'b0, '0);

    $display("[TB] redirect to 0x203 while a request waits for grant");
    doReset();
    lat_min = 1; lat_max = 1;
    repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0203);
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    repeat (10) applyStimulus(1'b1, 1'b1, 1'b0, '0);

    $display("[TB] fetch across the top of the address space");
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    repeat (8) applyStimulus(1'b1, 1'b1, 1'b0, '0);

    $display("[TB] random traffic");
    lat_min = 1; lat_max = 4;
    runRandom(2500, 70, 70, 3);
    lat_min = 1; lat_max = 2;
    runRandom(500, 95, 95, 1);

    $display("[TB] asynchronous reset while draining");
    lat_min = 3; lat_max = 3;
    repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0400);
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    doReset();
    lat_min = 1; lat_max = 1;
    repeat (10) applyStimulus(1'b1, 1'b1, 1'b0, '0);

    checkOutput("progress", (popped >= 300) ? 32'd1 : 32'd0, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
